rr_arbiter_mux: RTL and testbench

- Parametrised N-way arbitrating mux; next generation of the one-hot mux_8.
- Select is computed internally: round-robin or fixed-priority arbitration over per-way valid requests, replacing the external one-hot sel_in.
- Output is registered, with a valid/ready handshake on every input way and on the output.
- Shared-resource front end wherever several producers feed one consumer (e.g. multiple request queues into one pipeline port).

---
 rtl/rr_arbiter_mux_if.sv | 39 +++
 rtl/rr_arbiter_mux.sv | 99 +++++++++
 tb/tb_rr_arbiter_mux.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_mux_if.sv
// Handshake bundle between N producers, the arbitrating mux and one consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface rr_arbiter_mux_if #(
    parameter int NUMBER_WAYS                 = 8,
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 32
);
    localparam int INDEX_WIDTH = $clog2(NUMBER_WAYS);

    logic [NUMBER_WAYS-1:0]                             request_valid_in;
    logic [NUMBER_WAYS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] way_packed_in;
    logic [NUMBER_WAYS-1:0]                             request_ready_out;
    logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]             way_packed_out;
    logic                                               valid_out;
    logic                                               ready_in;
    logic [NUMBER_WAYS-1:0]                             grant_onehot_out;
    logic [INDEX_WIDTH-1:0]                             grant_index_out;

    modport master (
        output request_valid_in,
        output way_packed_in,
        output ready_in,
        input  request_ready_out,
        input  way_packed_out,
        input  valid_out,
        input  grant_onehot_out,
        input  grant_index_out
    );

    modport slave (
        input  request_valid_in,
        input  way_packed_in,
        input  ready_in,
        output request_ready_out,
        output way_packed_out,
        output valid_out,
        output grant_onehot_out,
        output grant_index_out
    );
endinterface

// File: rtl/rr_arbiter_mux.sv
// N-way arbitrating mux with a registered output stage: round-robin or fixed
// priority select over per-way valid requests, valid/ready on every side.
module rr_arbiter_mux #(
    parameter int NUMBER_WAYS                 = 8,
    parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 32,
    parameter int PRIORITY_MODE               = 0,
    parameter int INDEX_WIDTH                 = $clog2(NUMBER_WAYS)
) (
    input  logic               clk,
    input  logic               reset_in,
    rr_arbiter_mux_if.slave    bus
);
    localparam int W = SINGLE_ELEMENT_SIZE_IN_BITS;

    logic [W-1:0]             way_payload [NUMBER_WAYS];
    logic [NUMBER_WAYS-1:0]   winner_onehot;
    logic [INDEX_WIDTH-1:0]   ptr_reg;
    logic [INDEX_WIDTH-1:0]   rr_winner;
    logic                     rr_found;
    logic [INDEX_WIDTH-1:0]   fp_winner;
    logic                     fp_found;
    logic [INDEX_WIDTH-1:0]   winner;
    logic                     any_request;
    logic                     load_en;
    logic                     accept;

    logic [W-1:0]             data_reg;
    logic                     valid_reg;
    logic [NUMBER_WAYS-1:0]   grant_onehot_reg;
    logic [INDEX_WIDTH-1:0]   grant_index_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUMBER_WAYS; gi++) begin : g_way
            assign way_payload[gi]   = bus.way_packed_in[gi*W +: W];
            assign winner_onehot[gi] = (winner == INDEX_WIDTH'(gi));
        end
    endgenerate

    // Round-robin: first requester at or after the pointer, wrapping N-1 -> 0.
    always_comb begin : rr_search
        int idx;
        rr_found  = 1'b0;
        rr_winner = '0;
        idx       = 0;
        for (int k = 0; k < NUMBER_WAYS; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= NUMBER_WAYS) begin
                idx = idx - NUMBER_WAYS;
            end
            if (!rr_found && bus.request_valid_in[idx]) begin
                rr_found  = 1'b1;
                rr_winner = INDEX_WIDTH'(idx);
            end
        end
    end

    always_comb begin : fp_search
        fp_found  = 1'b0;
        fp_winner = '0;
        for (int k = 0; k < NUMBER_WAYS; k++) begin
            if (!fp_found && bus.request_valid_in[k]) begin
                fp_found  = 1'b1;
                fp_winner = INDEX_WIDTH'(k);
            end
        end
    end

    assign winner      = (PRIORITY_MODE != 0) ? fp_winner : rr_winner;
    assign any_request = |bus.request_valid_in;
    assign load_en     = ~valid_reg | bus.ready_in;
    // Reset gates the accept so no upstream element is consumed while held in reset.
    assign accept      = load_en & any_request & ~reset_in;

    assign bus.request_ready_out = accept ? winner_onehot : '0;

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            data_reg         <= '0;
            valid_reg        <= 1'b0;
            grant_onehot_reg <= '0;
            grant_index_reg  <= '0;
            ptr_reg          <= '0;
        end else if (accept) begin
            data_reg         <= way_payload[winner];
            valid_reg        <= 1'b1;
            grant_onehot_reg <= winner_onehot;
            grant_index_reg  <= winner;
            ptr_reg          <= (winner == INDEX_WIDTH'(NUMBER_WAYS - 1)) ? '0 : winner + 1'b1;
        end else if (bus.ready_in) begin
            valid_reg        <= 1'b0;
        end
    end

    assign bus.way_packed_out   = data_reg;
    assign bus.valid_out        = valid_reg;
    assign bus.grant_onehot_out = grant_onehot_reg;
    assign bus.grant_index_out  = grant_index_reg;
endmodule

// File: tb/tb_rr_arbiter_mux.sv
// Directed bench for rr_arbiter_mux: one round-robin and one fixed-priority
// instance, hand-computed expectations, one line per granted transaction.
module tb_rr_arbiter_mux;
    localparam int N = 8;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_mux_if #(.NUMBER_WAYS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W)) if_rr ();
    rr_arbiter_mux_if #(.NUMBER_WAYS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W)) if_fp ();

    rr_arbiter_mux #(.NUMBER_WAYS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W), .PRIORITY_MODE(0)) dut_rr (
        .clk      (clk),
        .reset_in (rst),
        .bus      (if_rr.slave)
    );

    rr_arbiter_mux #(.NUMBER_WAYS(N), .SINGLE_ELEMENT_SIZE_IN_BITS(W), .PRIORITY_MODE(1)) dut_fp (
        .clk      (clk),
        .reset_in (rst),
        .bus      (if_fp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rr_payload(input int way, input logic [W-1:0] v);
        if_rr.way_packed_in[way*W +: W] = v;
    endtask

    task automatic set_fp_payload(input int way, input logic [W-1:0] v);
        if_fp.way_packed_in[way*W +: W] = v;
    endtask

    // Advance one clock and confirm the round-robin output register holds the expected grant.
    task automatic rr_edge_expect(input string tag, input int idx, input logic [W-1:0] data);
        logic [N-1:0] oh;
        @(posedge clk);
        #1;
        oh = '0;
        oh[idx] = 1'b1;
        check({tag, "_valid"}, 64'(if_rr.valid_out), 64'd1);
        check({tag, "_index"}, 64'(if_rr.grant_index_out), 64'(idx));
        check({tag, "_onehot"}, 64'(if_rr.grant_onehot_out), 64'(oh));
        check({tag, "_data"}, 64'(if_rr.way_packed_out), 64'(data));
        $display("%0t rr grant way %0d data %08h", $time, if_rr.grant_index_out, if_rr.way_packed_out);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #3 rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        if_rr.request_valid_in = 8'hFF;
        if_rr.way_packed_in    = '0;
        if_rr.ready_in         = 1'b0;
        if_fp.request_valid_in = '0;
        if_fp.way_packed_in    = '0;
        if_fp.ready_in         = 1'b0;

        // Reset state: everything cleared and no accept even with requests pending
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(if_rr.valid_out), 64'd0);
        check("rst_data", 64'(if_rr.way_packed_out), 64'd0);
        check("rst_onehot", 64'(if_rr.grant_onehot_out), 64'd0);
        check("rst_index", 64'(if_rr.grant_index_out), 64'd0);
        check("rst_ready", 64'(if_rr.request_ready_out), 64'd0);
        if_rr.request_valid_in = '0;
        #2 rst = 1'b0;

        // 1: single request on way 2
        @(posedge clk);
        #1;
        set_rr_payload(2, 32'hDEAD_0002);
        if_rr.request_valid_in = 8'h04;
        if_rr.ready_in         = 1'b1;
        #1;
        check("t1_ready", 64'(if_rr.request_ready_out), 64'h04);
        rr_edge_expect("t1", 2, 32'hDEAD_0002);
        if_rr.request_valid_in = '0;
        @(posedge clk);
        #1;
        check("t1_drain_valid", 64'(if_rr.valid_out), 64'd0);
        check("t1_drain_hold", 64'(if_rr.way_packed_out), 64'hDEAD_0002);

        // 2: fairness from a fresh pointer, payload of way i = i
        pulse_reset();
        for (int i = 0; i < N; i++) set_rr_payload(i, 32'(i));
        if_rr.request_valid_in = 8'hFF;
        if_rr.ready_in         = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("t2_ready_%0d", c), 64'(if_rr.request_ready_out), 64'(8'h01 << (c % N)));
            rr_edge_expect($sformatf("t2_c%0d", c), c % N, 32'(c % N));
        end

        // 3: backpressure with the pointer at 2; output holds way 1's element
        set_rr_payload(4, 32'h44);
        set_rr_payload(5, 32'h55);
        if_rr.request_valid_in = 8'h30;
        if_rr.ready_in         = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t3_stall_ready_%0d", c), 64'(if_rr.request_ready_out), 64'd0);
            check($sformatf("t3_stall_data_%0d", c), 64'(if_rr.way_packed_out), 64'h1);
            check($sformatf("t3_stall_valid_%0d", c), 64'(if_rr.valid_out), 64'd1);
            @(posedge clk);
            #1;
        end
        if_rr.ready_in = 1'b1;
        #1;
        check("t3_release_ready", 64'(if_rr.request_ready_out), 64'h10);
        rr_edge_expect("t3_w4", 4, 32'h44);
        check("t3_next_ready", 64'(if_rr.request_ready_out), 64'h20);
        rr_edge_expect("t3_w5", 5, 32'h55);

        // 4: pointer at 6, requests on 7 and 0 -> 7 then wrap to 0
        set_rr_payload(7, 32'h77);
        set_rr_payload(0, 32'hA0);
        if_rr.request_valid_in = 8'h81;
        #1;
        check("t4_ready_w7", 64'(if_rr.request_ready_out), 64'h80);
        rr_edge_expect("t4_w7", 7, 32'h77);
        check("t4_ready_w0", 64'(if_rr.request_ready_out), 64'h01);
        rr_edge_expect("t4_w0", 0, 32'hA0);
        if_rr.request_valid_in = '0;

        // 5: fixed priority keeps way 1 ahead of way 3
        set_fp_payload(1, 32'h11);
        set_fp_payload(3, 32'h33);
        if_fp.request_valid_in = 8'h0A;
        if_fp.ready_in         = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t5_ready_%0d", c), 64'(if_fp.request_ready_out), 64'h02);
            @(posedge clk);
            #1;
            check($sformatf("t5_index_%0d", c), 64'(if_fp.grant_index_out), 64'd1);
            check($sformatf("t5_data_%0d", c), 64'(if_fp.way_packed_out), 64'h11);
            $display("%0t fp grant way %0d data %08h", $time, if_fp.grant_index_out, if_fp.way_packed_out);
        end
        if_fp.request_valid_in = 8'h08;
        #1;
        check("t5_w3_ready", 64'(if_fp.request_ready_out), 64'h08);
        @(posedge clk);
        #1;
        check("t5_w3_index", 64'(if_fp.grant_index_out), 64'd3);
        check("t5_w3_data", 64'(if_fp.way_packed_out), 64'h33);
        $display("%0t fp grant way %0d data %08h", $time, if_fp.grant_index_out, if_fp.way_packed_out);
        if_fp.request_valid_in = '0;

        // 6: load way 5 (pointer -> 6), stall, then async reset mid-cycle
        set_rr_payload(5, 32'h55);
        if_rr.request_valid_in = 8'h20;
        if_rr.ready_in         = 1'b1;
        rr_edge_expect("t6_w5", 5, 32'h55);
        set_rr_payload(1, 32'h11);
        set_rr_payload(7, 32'h77);
        if_rr.request_valid_in = 8'h82;
        if_rr.ready_in         = 1'b0;
        @(posedge clk);
        #1;
        check("t6_stall_ready", 64'(if_rr.request_ready_out), 64'd0);
        check("t6_stall_valid", 64'(if_rr.valid_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(if_rr.valid_out), 64'd0);
        check("t6_rst_data", 64'(if_rr.way_packed_out), 64'd0);
        check("t6_rst_index", 64'(if_rr.grant_index_out), 64'd0);
        check("t6_rst_ready", 64'(if_rr.request_ready_out), 64'd0);
        #2 rst = 1'b0;
        if_rr.ready_in = 1'b1;
        #1;
        check("t6_post_ready", 64'(if_rr.request_ready_out), 64'h02);
        rr_edge_expect("t6_post", 1, 32'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
